alarm_control_fsm: RTL and testbench
====================================

# alarm_control_fsm

Main control state machine of the anti-theft alarm. It sits directly upstream of `timer`: it selects and loads the countdown `value`, pulses `start_timer`, and consumes the timer's `expired`. It holds the four programmable interval registers, and drives the siren enable and the status LED from door and ignition inputs.

## Interface
Parameters:
- `CYCLES_PER_SEC`, default 10: clock cycles per second, used for the LED blink. The test scale is 10; hardware uses 100_000_000.
- `T_ARM_DEF`, default 4'd6: reset value of the arming delay, in seconds.
- `T_DRIVER_DEF`, default 4'd8: reset value of the driver-door entry delay.
- `T_PASS_DEF`, default 4'd15: reset value of the passenger-door entry delay.
- `T_ALARM_DEF`, default 4'd10: reset value of the siren-on interval.

Ports:
- `clock` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `ignition` in 1: ignition switch level.
- `driver_door` in 1: 1 = driver door open.
- `passenger_door` in 1: 1 = passenger door open.
- `reprogram` in 1: one-cycle write strobe for an interval register.
- `param_sel` in 2: register select. 0 = ARM, 1 = DRIVER, 2 = PASS, 3 = ALARM.
- `param_value` in 4: new interval in seconds.
- `expired` in 1: from `timer`. It may be a single-cycle pulse.
- `value` out 4: interval to `timer`. Registered; held between loads.
- `start_timer` out 1: registered, one-cycle load pulse to `timer`.
- `siren_on` out 1: siren enable level.
- `status_led` out 1: status indicator.

## Operation
There are six states, encoded in 3 bits: ARMED, TRIGGERED, SOUND, DISARMED, DOOR_OPEN, ARM_DELAY.

- **ARMED**
  - LED blinks; siren off.
  - `driver_door` → TRIGGERED, loading DRIVER.
  - Else `passenger_door` → TRIGGERED, loading PASS. Driver wins if both doors open.
  - `ignition` is ignored in this state.
- **TRIGGERED**
  - LED on; siren off.
  - `ignition` → DISARMED.
  - Else qualified `expired` → SOUND, loading ALARM.
- **SOUND**
  - LED on; siren on.
  - `ignition` → DISARMED.
  - Else qualified `expired` with any door open → stay in SOUND and reload ALARM.
  - Qualified `expired` with both doors closed → ARMED.
- **DISARMED**
  - LED off; siren off.
  - `!ignition && driver_door` → DOOR_OPEN.
- **DOOR_OPEN**
  - LED off.
  - `ignition` → DISARMED.
  - Else `!driver_door` → ARM_DELAY, loading ARM.
- **ARM_DELAY**
  - LED off.
  - Priority: `ignition` → DISARMED, then `driver_door` → DOOR_OPEN, then qualified `expired` → ARMED.

"Loading X" means, on the transition edge:
- `value` ← register X.
- `start_timer` ← 1 for exactly one cycle.

Interval registers:
- 4 × 4-bit.
- Reset to the `*_DEF` parameters.
- Written on `reprogram` with `param_value` at index `param_sel`.
- A write also forces state to ARMED, clears the blink counter, and sets LED to 0.
- `reprogram` has priority over every transition except reset.
- `start_timer` is not pulsed on a `reprogram` write; any pending expiry is discarded.

Blink:
- Counter runs 0..CYCLES_PER_SEC-1, only in ARMED.
- `status_led` toggles on wrap, giving a 2 s period.
- Entering ARMED clears the counter and sets LED to 0.

Values are loaded unchanged. A value of 0 yields an immediate expiry, accepted one cycle after load.

## Timing
- Reset values: state ARMED, `value`=0, `start_timer`=0, `siren_on`=0, `status_led`=0, blink counter 0, registers at defaults.
- Input to state: one-cycle latency. An input sampled at edge k gives the new state, `start_timer`=1 and the new `value` in cycle k+1.
- `siren_on` and `status_led` are registered and track state with no extra cycle.
- Expired qualification:
  - `expired` is ignored in the cycle `start_timer`=1, because the timer has not loaded yet.
  - From the next cycle, `expired` is accepted whenever it is high while in TRIGGERED, SOUND or ARM_DELAY.
  - It is ignored in all other states.
- Timer behaviour to tolerate: `expired` can be high while the timer is idle, and can be high for only one cycle.
- Mid-operation reset returns to the reset values asynchronously. The timer is not restarted.

## Test plan
Setup: `CYCLES_PER_SEC`=10, bench instantiates `timer`.

1. Reset, hold doors closed for 40 cycles → `status_led` toggles every 10 cycles; `start_timer` stays 0.
2. ARMED, set both doors=1 at edge k → TRIGGERED at k+1, `value`=8, `start_timer`=1 for one cycle. About 80 cycles later the `expired` pulse moves to SOUND: `siren_on`=1, `value`=10, `start_timer`=1.
3. In SOUND, keep `passenger_door`=1 through expiry → stays in SOUND and reloads 10. Close the door → next expiry goes to ARMED, `siren_on`=0, `status_led`=0.
4. In TRIGGERED, assert `ignition` in the same cycle as `expired` → DISARMED, `siren_on`=0.
5. DISARMED, `ignition`=0, open then close driver door → ARM_DELAY with `value`=6. Reopen mid-count → DOOR_OPEN. Close and let it expire → ARMED.
6. `reprogram` with `param_sel`=1, `param_value`=3 while in SOUND → ARMED next cycle. Then open driver door → `value`=3.

Source files
------------

// File: rtl/alarm_control_fsm.sv
// Main control FSM of the anti-theft alarm: sequences arming, entry delay and siren,
// loads the countdown timer, and owns the four programmable interval registers.
module alarm_control_fsm #(
  parameter int         CYCLES_PER_SEC = 10,
  parameter logic [3:0] T_ARM_DEF      = 4'd6,
  parameter logic [3:0] T_DRIVER_DEF   = 4'd8,
  parameter logic [3:0] T_PASS_DEF     = 4'd15,
  parameter logic [3:0] T_ALARM_DEF    = 4'd10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ignition,
  input  logic       driver_door,
  input  logic       passenger_door,
  input  logic       reprogram,
  input  logic [1:0] param_sel,
  input  logic [3:0] param_value,
  input  logic       expired,
  output logic [3:0] value,
  output logic       start_timer,
  output logic       siren_on,
  output logic       status_led
);

  typedef enum logic [2:0] {
    ARMED     = 3'd0,
    TRIGGERED = 3'd1,
    SOUND     = 3'd2,
    DISARMED  = 3'd3,
    DOOR_OPEN = 3'd4,
    ARM_DELAY = 3'd5
  } state_t;

  localparam int CNT_W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES_PER_SEC - 1);

  localparam logic [1:0] SEL_ARM    = 2'd0;
  localparam logic [1:0] SEL_DRIVER = 2'd1;
  localparam logic [1:0] SEL_PASS   = 2'd2;
  localparam logic [1:0] SEL_ALARM  = 2'd3;

  state_t           state_q, state_d;
  logic [3:0]       value_q, value_d;
  logic             start_q, start_d;
  logic             siren_q, siren_d;
  logic             led_q, led_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       regs_q [4];

  logic             load;
  logic [1:0]       load_sel;
  logic             exp_ok;

  // The timer has not latched the new value yet in the cycle start_timer is high.
  assign exp_ok = expired && !start_q;

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_sel = SEL_ARM;

    case (state_q)
      ARMED: begin
        if (driver_door) begin
          state_d  = TRIGGERED;
          load     = 1'b1;
          load_sel = SEL_DRIVER;
        end else if (passenger_door) begin
          state_d  = TRIGGERED;
          load     = 1'b1;
          load_sel = SEL_PASS;
        end
      end
      TRIGGERED: begin
        if (ignition) begin
          state_d = DISARMED;
        end else if (exp_ok) begin
          state_d  = SOUND;
          load     = 1'b1;
          load_sel = SEL_ALARM;
        end
      end
      SOUND: begin
        if (ignition) begin
          state_d = DISARMED;
        end else if (exp_ok) begin
          if (driver_door || passenger_door) begin
            load     = 1'b1;
            load_sel = SEL_ALARM;
          end else begin
            state_d = ARMED;
          end
        end
      end
      DISARMED: begin
        if (!ignition && driver_door) state_d = DOOR_OPEN;
      end
      DOOR_OPEN: begin
        if (ignition) begin
          state_d = DISARMED;
        end else if (!driver_door) begin
          state_d  = ARM_DELAY;
          load     = 1'b1;
          load_sel = SEL_ARM;
        end
      end
      ARM_DELAY: begin
        if (ignition)         state_d = DISARMED;
        else if (driver_door) state_d = DOOR_OPEN;
        else if (exp_ok)      state_d = ARMED;
      end
      default: state_d = ARMED;
    endcase

    // A register write overrides any transition and never starts the timer.
    if (reprogram) begin
      state_d = ARMED;
      load    = 1'b0;
    end

    value_d = load ? regs_q[load_sel] : value_q;
    start_d = load;
    siren_d = (state_d == SOUND);

    cnt_d = '0;
    led_d = (state_d == TRIGGERED) || (state_d == SOUND);
    if (state_d == ARMED) begin
      led_d = 1'b0;
      if (state_q == ARMED && !reprogram) begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          led_d = ~led_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
          led_d = led_q;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ARMED;
      value_q   <= 4'd0;
      start_q   <= 1'b0;
      siren_q   <= 1'b0;
      led_q     <= 1'b0;
      cnt_q     <= '0;
      regs_q[0] <= T_ARM_DEF;
      regs_q[1] <= T_DRIVER_DEF;
      regs_q[2] <= T_PASS_DEF;
      regs_q[3] <= T_ALARM_DEF;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      start_q <= start_d;
      siren_q <= siren_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      if (reprogram) regs_q[param_sel] <= param_value;
    end
  end

  assign value       = value_q;
  assign start_timer = start_q;
  assign siren_on    = siren_q;
  assign status_led  = led_q;

endmodule

// File: tb/tb_alarm_control_fsm.sv
// Randomized bench for alarm_control_fsm against a behavioural model of the alarm rules.
module tb_alarm_control_fsm;

  localparam int CPS = 10;

  localparam int S_ARMED = 0;
  localparam int S_TRIG  = 1;
  localparam int S_SOUND = 2;
  localparam int S_DIS   = 3;
  localparam int S_DOOR  = 4;
  localparam int S_DELAY = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ignition = 1'b0;
  logic       driver_door = 1'b0;
  logic       passenger_door = 1'b0;
  logic       reprogram = 1'b0;
  logic [1:0] param_sel = 2'd0;
  logic [3:0] param_value = 4'd0;
  logic       expired = 1'b0;
  logic [3:0] value;
  logic       start_timer;
  logic       siren_on;
  logic       status_led;

  int n_vec  = 0;
  int n_fail = 0;

  int m_state, m_value, m_start, m_siren, m_led, m_t;
  int m_regs [4];

  alarm_control_fsm #(.CYCLES_PER_SEC(CPS)) dut (
    .clock          (clock),
    .reset          (reset),
    .ignition       (ignition),
    .driver_door    (driver_door),
    .passenger_door (passenger_door),
    .reprogram      (reprogram),
    .param_sel      (param_sel),
    .param_value    (param_value),
    .expired        (expired),
    .value          (value),
    .start_timer    (start_timer),
    .siren_on       (siren_on),
    .status_led     (status_led)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("value", int'(value), m_value);
    chk("start_timer", int'(start_timer), m_start);
    chk("siren_on", int'(siren_on), m_siren);
    chk("status_led", int'(status_led), m_led);
  endtask

  task automatic model_reset();
    m_state = S_ARMED;
    m_value = 0;
    m_start = 0;
    m_siren = 0;
    m_led   = 0;
    m_t     = 0;
    m_regs[0] = 6;
    m_regs[1] = 8;
    m_regs[2] = 15;
    m_regs[3] = 10;
  endtask

  // One clock edge of the alarm rules; m_t counts cycles spent in ARMED since entry.
  task automatic model_step();
    bit acc;
    int ns;
    int ld;
    acc = expired && (m_start == 0);
    ns  = m_state;
    ld  = -1;
    if (reprogram) begin
      m_regs[param_sel] = int'(param_value);
      ns = S_ARMED;
    end else begin
      case (m_state)
        S_ARMED: begin
          if (driver_door)         begin ns = S_TRIG; ld = 1; end
          else if (passenger_door) begin ns = S_TRIG; ld = 2; end
        end
        S_TRIG: begin
          if (ignition) ns = S_DIS;
          else if (acc) begin ns = S_SOUND; ld = 3; end
        end
        S_SOUND: begin
          if (ignition) ns = S_DIS;
          else if (acc) begin
            if (driver_door || passenger_door) ld = 3;
            else ns = S_ARMED;
          end
        end
        S_DIS: if (!ignition && driver_door) ns = S_DOOR;
        S_DOOR: begin
          if (ignition) ns = S_DIS;
          else if (!driver_door) begin ns = S_DELAY; ld = 0; end
        end
        S_DELAY: begin
          if (ignition)         ns = S_DIS;
          else if (driver_door) ns = S_DOOR;
          else if (acc)         ns = S_ARMED;
        end
        default: ns = S_ARMED;
      endcase
    end
    m_start = (ld >= 0) ? 1 : 0;
    if (ld >= 0) m_value = m_regs[ld];
    if (ns == S_ARMED) m_t = (m_state == S_ARMED && !reprogram) ? m_t + 1 : 0;
    m_state = ns;
    m_siren = (ns == S_SOUND) ? 1 : 0;
    if (ns == S_ARMED) m_led = (m_t / CPS) % 2;
    else m_led = (ns == S_TRIG || ns == S_SOUND) ? 1 : 0;
  endtask

  initial begin
    model_reset();
    #1;
    check_outputs();
    @(negedge clock);
    reset = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc == 2000) begin
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        #3;
        reset = 1'b0;
      end

      if (cyc < 45) begin
        ignition = 1'b0; driver_door = 1'b0; passenger_door = 1'b0;
        reprogram = 1'b0; expired = 1'b0;
      end else begin
        if ($urandom_range(99) < 4) ignition = ~ignition;
        if ($urandom_range(99) < 6) driver_door = ~driver_door;
        if ($urandom_range(99) < 6) passenger_door = ~passenger_door;
        expired     = ($urandom_range(99) < 15);
        reprogram   = ($urandom_range(99) < 2);
        param_sel   = 2'($urandom_range(3));
        param_value = 4'($urandom_range(15));
      end

      @(posedge clock);
      model_step();
      @(negedge clock);
      check_outputs();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
